ccff_chain_loader: RTL and testbench

- Configuration controller that programs one configuration-chain segment, such as a switch-block mux memory chain, from a word-wide bitstream source.
- Accepts bitstream words over a valid/ready handshake and serializes them LSB-first onto ccff_head, one bit per shift cycle.
- Gates chain shifting with ccff_shift_en and counts exactly CHAIN_LEN bits.
- Captures the previous chain contents from ccff_tail as readback words.
- Sits between the top-level bitstream fetch logic and the ccff_head/ccff_tail ports of a tile.

---
 rtl/ccff_chain_loader.sv | 167 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Programs one configuration-chain segment from a word-wide
//            bitstream. Words are accepted over valid/ready, shifted LSB-first
//            onto ccff_head for exactly CHAIN_LEN shift cycles, and the old
//            chain contents leaving ccff_tail are packed into readback words.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 8,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_loaded
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   localparam logic [1:0] C_IDLE      = 2'd0;
   localparam logic [1:0] C_WAIT_WORD = 2'd1;
   localparam logic [1:0] C_SHIFT     = 2'd2;
   localparam logic [1:0] C_DONE      = 2'd3;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [WORD_W-1:0] shreg_q;
   logic [WORD_W-1:0] rb_acc_q;
   logic [WORD_W-1:0] rb_data_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              head_q;
   logic              rb_valid_q;

   logic [WORD_W-1:0] w_shreg_shift;
   logic [WORD_W-1:0] w_rb_word;
   logic              w_last_bit;
   logic              w_last_word_bit;

   // The bit being shifted out this cycle is the final one of the load / of the word.
   assign w_last_bit      = (cnt_q == C_CNT_LAST);
   assign w_last_word_bit = (idx_q == C_IDX_LAST);
   assign w_shreg_shift   = shreg_q >> 1;

   // State register.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q <= C_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = C_IDLE;
      end else begin
         case (state_q)
            C_IDLE, C_DONE: if (start)      state_d = C_WAIT_WORD;
            C_WAIT_WORD:    if (word_valid) state_d = C_SHIFT;
            C_SHIFT: begin
               if (w_last_bit)           state_d = C_DONE;
               else if (w_last_word_bit) state_d = C_WAIT_WORD;
            end
            default:                     state_d = C_IDLE;
         endcase
      end
   end

   // State-decoded outputs; these drop with the asynchronous reset.
   always_comb begin
      word_ready    = (state_q == C_WAIT_WORD);
      ccff_shift_en = (state_q == C_SHIFT);
      busy          = (state_q == C_WAIT_WORD) || (state_q == C_SHIFT);
      done          = (state_q == C_DONE);
   end

   // Readback word including the tail bit being sampled on this edge.
   always_comb begin
      w_rb_word        = rb_acc_q;
      w_rb_word[idx_q] = ccff_tail;
   end

   // Datapath: word shifter, bit counters, head bit and readback packing.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         shreg_q    <= '0;
         rb_acc_q   <= '0;
         rb_data_q  <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         head_q     <= 1'b0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_valid_q <= 1'b0;
         if (abort) begin
            // A partially packed readback word is dropped, never emitted.
            shreg_q  <= '0;
            rb_acc_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            head_q   <= 1'b0;
         end else begin
            case (state_q)
               C_IDLE, C_DONE: begin
                  if (start) begin
                     rb_acc_q <= '0;
                     idx_q    <= '0;
                     cnt_q    <= '0;
                     head_q   <= 1'b0;
                  end
               end
               C_WAIT_WORD: begin
                  if (word_valid) begin
                     shreg_q <= word_data;
                     head_q  <= word_data[0];
                     idx_q   <= '0;
                  end
               end
               C_SHIFT: begin
                  cnt_q   <= cnt_q + CNT_W'(1);
                  idx_q   <= idx_q + IDX_W'(1);
                  shreg_q <= w_shreg_shift;
                  if (w_last_bit || w_last_word_bit) begin
                     // Word boundary or end of chain: leftover word bits are discarded.
                     head_q     <= 1'b0;
                     rb_data_q  <= w_rb_word;
                     rb_valid_q <= 1'b1;
                     rb_acc_q   <= '0;
                  end else begin
                     head_q   <= w_shreg_shift[0];
                     rb_acc_q <= w_rb_word;
                  end
               end
               default: begin
                  head_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ccff_head   = head_q;
   assign rb_data     = rb_data_q;
   assign rb_valid    = rb_valid_q;
   assign bits_loaded = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Self-checking bench for ccff_chain_loader with a behavioural
//            model of the configuration chain and a stream-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

   localparam int L  = 10;
   localparam int W  = 8;
   localparam int NW = (L + W - 1) / W;
   localparam int CW = $clog2(L + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          word_valid = 1'b0;
   logic [W-1:0]  word_data = '0;
   logic          word_ready;
   logic          ccff_head;
   logic          ccff_shift_en;
   logic          ccff_tail;
   logic [W-1:0]  rb_data;
   logic          rb_valid;
   logic          busy;
   logic          done;
   logic [CW-1:0] bits_loaded;

   logic [L-1:0]  chain = '0;
   logic          preload_req = 1'b0;
   logic [L-1:0]  preload_val = '0;
   bit            obs_head[$];
   logic [W-1:0]  obs_rb[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
      .prog_clk      (clk),
      .prog_reset_n  (rst_n),
      .start         (start),
      .abort         (abort),
      .word_data     (word_data),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rb_data       (rb_data),
      .rb_valid      (rb_valid),
      .busy          (busy),
      .done          (done),
      .bits_loaded   (bits_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Tile chain: head enters flop 0, tail is the last flop.
   always @(posedge clk) begin
      if (preload_req)        chain <= preload_val;
      else if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
   end
   assign ccff_tail = chain[L-1];

   // Observe shifted bits and readback words mid-cycle.
   always @(negedge clk) begin
      if (ccff_shift_en) obs_head.push_back(ccff_head);
      if (rb_valid)      obs_rb.push_back(rb_data);
   end

   initial begin
      #500000;
      $display("FAIL global_timeout cyc=%0d want completion", cyc);
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [L-1:0] v);
      preload_val = v;
      preload_req = 1'b1;
      tick;
      preload_req = 1'b0;
   endtask

   // One complete load, checked against a stream-level reference.
   task automatic run_load(input string tag, input logic [NW*W-1:0] stream,
                           input int max_gap, input int stall, input bit noise,
                           input bit chk_lat);
      logic [L-1:0] old_chain, exp_chain, exp_head, got_head;
      logic [W-1:0] exp_rb [NW];
      int h0, r0, t0, budget, gap;
      old_chain = chain;
      h0 = obs_head.size();
      r0 = obs_rb.size();
      exp_chain = '0;
      exp_head  = '0;
      for (int k = 0; k < L; k++) begin
         exp_head[k]      = stream[k];
         exp_chain[L-1-k] = stream[k];
      end
      for (int j = 0; j < NW; j++) exp_rb[j] = '0;
      for (int k = 0; k < L; k++) exp_rb[k / W][k % W] = old_chain[L-1-k];

      start = 1'b1;
      tick;
      start = 1'b0;
      t0 = cyc;
      for (int j = 0; j < NW; j++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         if (j == 1 && stall > 0) begin
            budget = 0;
            while (!word_ready && budget < 100) begin tick; budget++; end
            repeat (stall) begin
               checks++;
               if (ccff_shift_en !== 1'b0 || bits_loaded !== CW'(W) || word_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL %s_stall shift_en=%b bits_loaded=%0d ready=%b want 0/%0d/1",
                           tag, ccff_shift_en, bits_loaded, word_ready, W);
               end
               tick;
            end
         end
         repeat (gap) tick;
         word_data  = stream[j*W +: W];
         word_valid = 1'b1;
         budget = 0;
         while (!word_ready && budget < 100) begin
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            tick;
            budget++;
         end
         start = 1'b0;
         checks++;
         if (budget >= 100) begin
            errors++;
            $display("FAIL %s_ready_timeout word=%0d ready=%b want 1", tag, j, word_ready);
         end
         tick;
         word_valid = 1'b0;
         word_data  = W'($urandom);
      end

      budget = 0;
      while (done !== 1'b1 && budget < 200) begin tick; budget++; end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout done=%b want 1", tag, done);
      end
      if (chk_lat) begin
         checks++;
         if (cyc - t0 != L + NW) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", tag, cyc - t0, L + NW);
         end
      end
      tick;

      checks++;
      if (obs_head.size() - h0 != L) begin
         errors++;
         $display("FAIL %s_shift_count got=%0d want=%0d", tag, obs_head.size() - h0, L);
      end
      got_head = '0;
      for (int k = 0; k < L && h0 + k < obs_head.size(); k++) got_head[k] = obs_head[h0 + k];
      checks++;
      if (got_head !== exp_head) begin
         errors++;
         $display("FAIL %s_head_bits got=%h want=%h", tag, got_head, exp_head);
      end
      checks++;
      if (obs_rb.size() - r0 != NW) begin
         errors++;
         $display("FAIL %s_rb_count got=%0d want=%0d", tag, obs_rb.size() - r0, NW);
      end
      for (int j = 0; j < NW && r0 + j < obs_rb.size(); j++) begin
         checks++;
         if (obs_rb[r0 + j] !== exp_rb[j]) begin
            errors++;
            $display("FAIL %s_rb_word%0d got=%h want=%h", tag, j, obs_rb[r0 + j], exp_rb[j]);
         end
      end
      checks++;
      if ({done, busy, ccff_shift_en, ccff_head, word_ready} !== 5'b10000 || bits_loaded !== CW'(L)) begin
         errors++;
         $display("FAIL %s_final done/busy/sh/head/rdy=%b bits=%0d want 10000 bits=%0d",
                  tag, {done, busy, ccff_shift_en, ccff_head, word_ready}, bits_loaded, L);
      end
      checks++;
      if (chain !== exp_chain) begin
         errors++;
         $display("FAIL %s_chain got=%h want=%h", tag, chain, exp_chain);
      end
   endtask

   task automatic test_reset;
      preload(L'($urandom));
      checks++;
      if ({word_ready, ccff_head, ccff_shift_en, rb_valid, busy, done} !== 6'b0 ||
          rb_data !== '0 || bits_loaded !== '0) begin
         errors++;
         $display("FAIL reset_outputs ctl=%b rb=%h bits=%0d want all 0",
                  {word_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}, rb_data, bits_loaded);
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if ({busy, done, word_ready, ccff_shift_en} !== 4'b0) begin
         errors++;
         $display("FAIL reset_idle got=%b want 0000", {busy, done, word_ready, ccff_shift_en});
      end
   endtask

   task automatic test_valid_ignored;
      word_data  = W'($urandom);
      word_valid = 1'b1;
      repeat (4) tick;
      checks++;
      if ({word_ready, busy, ccff_shift_en} !== 3'b0 || bits_loaded !== '0) begin
         errors++;
         $display("FAIL valid_in_idle rdy/busy/sh=%b bits=%0d want 000 bits=0",
                  {word_ready, busy, ccff_shift_en}, bits_loaded);
      end
      word_valid = 1'b0;
   endtask

   task automatic test_readback;
      int r0;
      preload(10'h03C);
      run_load("directed", {8'hFF, 8'h12}, 0, 0, 1'b0, 1'b1);
      r0 = obs_rb.size();
      run_load("readback", 16'($urandom), 0, 0, 1'b0, 1'b0);
      checks++;
      if (r0 + 1 >= obs_rb.size() || obs_rb[r0] !== 8'h12 || obs_rb[r0 + 1] !== 8'h03) begin
         errors++;
         $display("FAIL readback_prev_load got=%h,%h want=12,03",
                  (r0 < obs_rb.size()) ? obs_rb[r0] : 8'hxx,
                  (r0 + 1 < obs_rb.size()) ? obs_rb[r0 + 1] : 8'hxx);
      end
   endtask

   task automatic test_stall;
      run_load("stall", 16'($urandom), 0, 5, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 5; i++) run_load("random", 16'($urandom), 3, 0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) run_load("b2b", 16'($urandom), 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_abort;
      int h0, r0, n, budget;
      h0 = obs_head.size();
      r0 = obs_rb.size();
      start = 1'b1;
      tick;
      start = 1'b0;
      word_data  = W'($urandom);
      word_valid = 1'b1;
      budget = 0;
      while (!word_ready && budget < 100) begin tick; budget++; end
      tick;
      word_valid = 1'b0;
      n = 1;
      while (n < 4) begin tick; n++; end
      checks++;
      if (ccff_shift_en !== 1'b1 || bits_loaded !== CW'(3)) begin
         errors++;
         $display("FAIL abort_pre sh=%b bits=%0d want 1 bits=3", ccff_shift_en, bits_loaded);
      end
      abort = 1'b1;
      tick;
      abort = 1'b0;
      checks++;
      if ({ccff_shift_en, busy, done, word_ready, rb_valid} !== 5'b0 || bits_loaded !== '0) begin
         errors++;
         $display("FAIL abort_idle sh/busy/done/rdy/rbv=%b bits=%0d want 00000 bits=0",
                  {ccff_shift_en, busy, done, word_ready, rb_valid}, bits_loaded);
      end
      repeat (3) tick;
      checks++;
      if (obs_rb.size() != r0) begin
         errors++;
         $display("FAIL abort_rb_pulses got=%0d want=0", obs_rb.size() - r0);
      end
      checks++;
      if (obs_head.size() - h0 != 4) begin
         errors++;
         $display("FAIL abort_shift_count got=%0d want=4", obs_head.size() - h0);
      end
      start = 1'b1;
      abort = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if ({busy, word_ready} !== 2'b00) begin
         errors++;
         $display("FAIL start_abort_same busy/rdy=%b want 00", {busy, word_ready});
      end
      run_load("after_abort", 16'($urandom), 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset;
      int budget;
      start = 1'b1;
      tick;
      start = 1'b0;
      word_data  = W'($urandom);
      word_valid = 1'b1;
      budget = 0;
      while (!word_ready && budget < 100) begin tick; budget++; end
      tick;
      word_valid = 1'b0;
      repeat (2) tick;
      checks++;
      if (ccff_shift_en !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre sh=%b want 1", ccff_shift_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({word_ready, ccff_head, ccff_shift_en, rb_valid, busy, done} !== 6'b0 ||
          rb_data !== '0 || bits_loaded !== '0) begin
         errors++;
         $display("FAIL areset_outputs ctl=%b rb=%h bits=%0d want all 0",
                  {word_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}, rb_data, bits_loaded);
      end
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      run_load("after_reset", 16'($urandom), 0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      tick;
      test_reset;
      test_valid_ignored;
      test_readback;
      test_stall;
      test_random;
      test_back_to_back;
      test_abort;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
